// File: rtl/fft_frame_serializer.sv
// -----------------------------------------------------------------------------
// fft_frame_serializer
//
// Captures 16-point FFT result frames, presented in parallel with a one-cycle
// strobe, into a two-bank frame buffer and replays each frame as a serial
// stream of DATA_W-bit words ({real, imag}) under a valid/ready handshake.
//
// Ports
//   clk          system clock, all state updates on the rising edge
//   rst          asynchronous reset, active low
//   fft_valid    one-cycle strobe, fft_d0..fft_d15 hold a complete frame
//   fft_d0..15   FFT points 0..15 of the current frame
//   out_valid    out_d / out_idx / out_last hold a valid word
//   out_ready    downstream accepts the current word this cycle
//   out_d        point out_idx of the oldest buffered frame
//   out_idx      point index 0..15 of out_d
//   out_last     high with the final word (index 15) of a frame
//   out_frame    number of completely sent frames, wraps modulo 2^FRAME_W
//   overflow     sticky flag, at least one frame was dropped
//   drop_cnt     number of dropped frames, saturates at all-ones
//   busy         at least one bank holds an unsent frame
// -----------------------------------------------------------------------------
module fft_frame_serializer #(
    parameter int DATA_W  = 32,
    parameter int FRAME_W = 6,
    parameter int DROP_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fft_valid,
    input  logic [DATA_W-1:0]  fft_d0,
    input  logic [DATA_W-1:0]  fft_d1,
    input  logic [DATA_W-1:0]  fft_d2,
    input  logic [DATA_W-1:0]  fft_d3,
    input  logic [DATA_W-1:0]  fft_d4,
    input  logic [DATA_W-1:0]  fft_d5,
    input  logic [DATA_W-1:0]  fft_d6,
    input  logic [DATA_W-1:0]  fft_d7,
    input  logic [DATA_W-1:0]  fft_d8,
    input  logic [DATA_W-1:0]  fft_d9,
    input  logic [DATA_W-1:0]  fft_d10,
    input  logic [DATA_W-1:0]  fft_d11,
    input  logic [DATA_W-1:0]  fft_d12,
    input  logic [DATA_W-1:0]  fft_d13,
    input  logic [DATA_W-1:0]  fft_d14,
    input  logic [DATA_W-1:0]  fft_d15,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_d,
    output logic [3:0]         out_idx,
    output logic               out_last,
    output logic [FRAME_W-1:0] out_frame,
    output logic               overflow,
    output logic [DROP_W-1:0]  drop_cnt,
    output logic               busy
);

    // Parallel frame input gathered into an array for indexed writes
    logic [DATA_W-1:0] fft_in [16];

    assign fft_in[0]  = fft_d0;
    assign fft_in[1]  = fft_d1;
    assign fft_in[2]  = fft_d2;
    assign fft_in[3]  = fft_d3;
    assign fft_in[4]  = fft_d4;
    assign fft_in[5]  = fft_d5;
    assign fft_in[6]  = fft_d6;
    assign fft_in[7]  = fft_d7;
    assign fft_in[8]  = fft_d8;
    assign fft_in[9]  = fft_d9;
    assign fft_in[10] = fft_d10;
    assign fft_in[11] = fft_d11;
    assign fft_in[12] = fft_d12;
    assign fft_in[13] = fft_d13;
    assign fft_in[14] = fft_d14;
    assign fft_in[15] = fft_d15;

    // Frame storage: two banks of 16 points, contents never reset
    logic [DATA_W-1:0] bank_q [2][16];

    // Control state
    logic               wr_bank_q,   wr_bank_d;
    logic               rd_bank_q,   rd_bank_d;
    logic [1:0]         full_q,      full_d;
    logic [3:0]         rd_idx_q,    rd_idx_d;
    logic [FRAME_W-1:0] out_frame_q, out_frame_d;
    logic               overflow_q,  overflow_d;
    logic [DROP_W-1:0]  drop_cnt_q,  drop_cnt_d;

    logic xfer;
    logic xfer_last;
    logic accept;

    always_comb begin
        xfer      = full_q[rd_bank_q] & out_ready;
        xfer_last = xfer & (rd_idx_q == 4'd15);

        // A full write bank may still be reused when it is the read bank and
        // its final word leaves on this very edge: the read of word 15 and
        // the overwrite coincide.
        accept = fft_valid &
                 (~full_q[wr_bank_q] | ((wr_bank_q == rd_bank_q) & xfer_last));

        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        full_d      = full_q;
        rd_idx_d    = rd_idx_q;
        out_frame_d = out_frame_q;
        overflow_d  = overflow_q;
        drop_cnt_d  = drop_cnt_q;

        if (xfer) begin
            // 4-bit index wraps from 15 back to 0 naturally
            rd_idx_d = rd_idx_q + 4'd1;
            if (xfer_last) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
                out_frame_d       = out_frame_q + FRAME_W'(1);
            end
        end

        // Capture is evaluated after the release so that the same-edge
        // overwrite leaves the bank marked full.
        if (accept) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
        end else if (fft_valid) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != {DROP_W{1'b1}}) begin
                drop_cnt_d = drop_cnt_q + DROP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            full_q      <= 2'b00;
            rd_idx_q    <= 4'd0;
            out_frame_q <= '0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            full_q      <= full_d;
            rd_idx_q    <= rd_idx_d;
            out_frame_q <= out_frame_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < 16; i++) begin
                bank_q[wr_bank_q][i] <= fft_in[i];
            end
        end
    end

    // Outputs come from registers only. The data word is gated by valid so
    // that it reads zero after reset even though bank contents are unknown.
    always_comb begin
        out_valid = full_q[rd_bank_q];
        out_d     = out_valid ? bank_q[rd_bank_q][rd_idx_q] : '0;
        out_idx   = rd_idx_q;
        out_last  = out_valid & (rd_idx_q == 4'd15);
        out_frame = out_frame_q;
        overflow  = overflow_q;
        drop_cnt  = drop_cnt_q;
        busy      = |full_q;
    end

endmodule

// File: tb/tb_fft_frame_serializer.sv
module tb_fft_frame_serializer;

    logic        clk;
    logic        rst;
    logic        fft_valid;
    logic [31:0] fd [16];
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_d;
    logic [3:0]  out_idx;
    logic        out_last;
    logic [5:0]  out_frame;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic        busy;

    logic ready_req;
    logic bp_mode;
    logic bp_ready;
    int   bp_cnt;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  idx;
    } exp_t;

    exp_t q[$];

    int total;
    int bad;

    fft_frame_serializer #(.DATA_W(32), .FRAME_W(6), .DROP_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .fft_valid (fft_valid),
        .fft_d0    (fd[0]),
        .fft_d1    (fd[1]),
        .fft_d2    (fd[2]),
        .fft_d3    (fd[3]),
        .fft_d4    (fd[4]),
        .fft_d5    (fd[5]),
        .fft_d6    (fd[6]),
        .fft_d7    (fd[7]),
        .fft_d8    (fd[8]),
        .fft_d9    (fd[9]),
        .fft_d10   (fd[10]),
        .fft_d11   (fd[11]),
        .fft_d12   (fd[12]),
        .fft_d13   (fd[13]),
        .fft_d14   (fd[14]),
        .fft_d15   (fd[15]),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_d     (out_d),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_frame (out_frame),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ready pattern 1,0,0,1 repeating for the backpressure test
    always @(posedge clk) begin
        #1;
        bp_ready = (bp_cnt % 4 == 0) || (bp_cnt % 4 == 3);
        bp_cnt   = bp_cnt + 1;
    end

    assign out_ready = bp_mode ? bp_ready : ready_req;

    // Frame f, point k: frame 0 gives 0000_0000, 0001_0001 .. 000F_000F
    function automatic logic [31:0] word(input int f, input int k);
        return 32'(f) * 32'h0100_0100 + 32'(k) * 32'h0001_0001;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total = total + 1;
        if (act !== req) begin
            bad = bad + 1;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every presented word must match the head of the scoreboard,
    // including during ready-low cycles; a handshake retires the head.
    always @(negedge clk) begin
        if (rst && out_valid) begin
            total = total + 1;
            if (q.size() == 0) begin
                bad = bad + 1;
                $display("FAIL unexpected_word actual=%h idx=%0d required=none", out_d, out_idx);
            end else begin
                if (out_d !== q[0].d || out_idx !== q[0].idx ||
                    out_last !== (q[0].idx == 4'd15)) begin
                    bad = bad + 1;
                    $display("FAIL word actual=%h/%0d/%b required=%h/%0d/%b",
                             out_d, out_idx, out_last, q[0].d, q[0].idx, (q[0].idx == 4'd15));
                end
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic send_frame(input int f, input bit push);
        exp_t e;
        for (int k = 0; k < 16; k++) begin
            fd[k] = word(f, k);
            if (push) begin
                e.d   = word(f, k);
                e.idx = 4'(k);
                q.push_back(e);
            end
        end
        fft_valid = 1'b1;
        @(posedge clk);
        #1;
        fft_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        int n;
        n = 0;
        while ((q.size() != 0 || busy) && n < max_cyc) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({"drain_", name}, 32'((q.size() == 0) && !busy), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        q.delete();
        repeat (3) @(posedge clk);
        #1;
        q.delete();
        rst = 1'b1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        bp_cnt    = 0;
        bp_mode   = 1'b0;
        bp_ready  = 1'b0;
        ready_req = 1'b0;
        fft_valid = 1'b0;
        for (int k = 0; k < 16; k++) fd[k] = '0;
        rst = 1'b1;
        #2;

        // 1: reset / idle
        do_reset();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_frame", 32'(out_frame), 32'd0);
        check("rst_overflow",  32'(overflow),  32'd0);
        check("rst_drop_cnt",  32'(drop_cnt),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_out_idx",   32'(out_idx),   32'd0);
        check("rst_out_d",     out_d,          32'd0);

        // 2: single frame, out_ready high
        ready_req = 1'b1;
        send_frame(0, 1'b1);
        check("single_valid_after_capture", 32'(out_valid), 32'd1);
        check("single_first_word", out_d, 32'h0000_0000);
        wait_drain("single", 40);
        check("single_out_frame", 32'(out_frame), 32'd1);
        check("single_busy", 32'(busy), 32'd0);

        // 3: backpressure, ready 1,0,0,1
        bp_mode = 1'b1;
        send_frame(0, 1'b1);
        wait_drain("backpressure", 120);
        bp_mode = 1'b0;
        check("bp_out_frame", 32'(out_frame), 32'd2);

        // 4: 64 frames back to back every 16 cycles
        do_reset();
        ready_req = 1'b1;
        for (int f = 0; f < 64; f++) begin
            send_frame(f, 1'b1);
            if (f == 31) check("stream_no_drop_mid", 32'(drop_cnt), 32'd0);
            repeat (15) @(posedge clk);
            #1;
        end
        wait_drain("stream", 60);
        check("stream_out_frame_wrap", 32'(out_frame), 32'd0);
        check("stream_drop_cnt", 32'(drop_cnt), 32'd0);
        check("stream_overflow", 32'(overflow), 32'd0);

        // 5: overflow with ready low, frames A, B kept, C dropped
        ready_req = 1'b0;
        send_frame(1, 1'b1);
        send_frame(2, 1'b1);
        send_frame(3, 1'b0);
        check("ovf_overflow", 32'(overflow), 32'd1);
        check("ovf_drop_cnt", 32'(drop_cnt), 32'd1);
        check("ovf_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 16; k++) fd[k] = 32'hDEAD_0000 + 32'(k);
        fft_valid = 1'b1;
        repeat (254) @(posedge clk);
        #1;
        check("ovf_drop_cnt_ff", 32'(drop_cnt), 32'hFF);
        @(posedge clk);
        #1;
        fft_valid = 1'b0;
        check("ovf_drop_cnt_sat", 32'(drop_cnt), 32'hFF);
        ready_req = 1'b1;
        wait_drain("ovf", 80);
        check("ovf_out_frame", 32'(out_frame), 32'd2);

        // 6a: both banks full, new frame lands on the word-15 transfer edge
        do_reset();
        ready_req = 1'b0;
        send_frame(10, 1'b1);
        send_frame(11, 1'b1);
        ready_req = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        send_frame(12, 1'b1);
        check("edge_drop_cnt", 32'(drop_cnt), 32'd0);
        check("edge_overflow", 32'(overflow), 32'd0);
        wait_drain("edge", 80);
        check("edge_out_frame", 32'(out_frame), 32'd3);

        // 6b: asynchronous reset during word 7
        do_reset();
        ready_req = 1'b1;
        send_frame(20, 1'b1);
        begin
            int n;
            n = 0;
            while (out_idx != 4'd7 && n < 40) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("arst_reached_word7", 32'(out_idx), 32'd7);
        end
        #2;
        rst = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_idx",   32'(out_idx),   32'd0);
        check("arst_out_d",     out_d,          32'd0);
        check("arst_busy",      32'(busy),      32'd0);
        check("arst_out_last",  32'(out_last),  32'd0);
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        send_frame(21, 1'b1);
        check("arst_restart_idx", 32'(out_idx), 32'd0);
        wait_drain("arst", 40);
        check("arst_out_frame", 32'(out_frame), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
